axi_bus_arbiter: RTL and testbench
==================================

# axi_bus_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the single MMU/memory bus between the fetch stage (read-only master F) and the mem stage (read/write master M). It serializes whole transactions: exactly one outstanding transaction at a time, round-robin between masters, with the granted master's channels forwarded to the downstream port. It sits between the core stages and the MMU bus.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; `wstrb` is DATA_W/8 bits
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- f_araddr/f_arprot/f_arvalid  in  ADDR_W/3/1  F read-address channel
- f_arready  out  1  F read-address ready
- f_rdata/f_rresp/f_rvalid  out  DATA_W/2/1  F read-data channel
- f_rready  in  1  F read-data ready
- m_araddr/m_arprot/m_arvalid, m_arready  in/out  ADDR_W/3/1, 1  M read-address channel
- m_rdata/m_rresp/m_rvalid, m_rready  out/in  DATA_W/2/1, 1  M read-data channel
- m_awaddr/m_awprot/m_awvalid, m_awready  in/out  ADDR_W/3/1, 1  M write-address channel
- m_wdata/m_wstrb/m_wvalid, m_wready  in/out  DATA_W/4/1, 1  M write-data channel
- m_bresp/m_bvalid, m_bready  out/in  2/1, 1  M write-response channel
- axi_* (ar, r, aw, w, b)  out/in  same widths  downstream master port to the MMU

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP. Registers: state, gnt (F or M), last (F or M), aw_done, w_done.
- IDLE: all forwarded valid/ready outputs are 0. Request sources:
  - reqF = f_arvalid
  - reqM = m_arvalid | m_awvalid
- IDLE arbitration, evaluated each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to `last` wins.
  - Winner M with m_awvalid set: go to WR_XFER, clearing aw_done and w_done.
  - Winner M otherwise, or winner F: go to RD_ADDR.
  - On any grant, set gnt and last to the winner.
  - If M asserts m_awvalid and m_arvalid together, the write is taken first.
- RD_ADDR:
  - axi_ar* = gnt's ar* fields; gnt's arready = axi_arready.
  - Leave on the axi_arvalid & axi_arready handshake and go to RD_DATA.
- RD_DATA:
  - axi_rready = gnt's rready.
  - gnt's rvalid = axi_rvalid; rdata and rresp pass through.
  - Leave on the axi_rvalid & axi_rready handshake and go to IDLE.
- WR_XFER:
  - aw and w are forwarded independently, each only while its done flag is clear (axi_awvalid = m_awvalid & !aw_done, same rule for w).
  - Each handshake sets its done flag.
  - Go to WR_RESP in the cycle both handshakes have happened (flag set, or handshake this cycle).
- WR_RESP:
  - axi_bready = m_bready; m_bvalid = axi_bvalid; bresp passes through.
  - On the b handshake, go to IDLE.
- Ungranted master: all of its ready/valid outputs are 0. Data and resp outputs to both masters are driven from downstream unconditionally; only valid is gated.
- rresp/bresp SLVERR/DECERR are passed through unchanged. There is no retry and no error handling.

## Timing
- Reset:
  - state = IDLE, last = F (M wins the first tie), gnt = F, done flags = 0.
  - All valid/ready outputs are 0 in the cycle after rst is sampled.
- Arbitration costs exactly 1 cycle: a request seen in IDLE in cycle N produces the forwarded axi_arvalid/axi_awvalid in cycle N+1.
- Forwarding is combinational within the granted state; the arbiter adds no pipeline registers on data paths.
- Return to IDLE costs 1 cycle after the final handshake. Minimum read occupancy with a zero-wait slave is 3 cycles (IDLE, RD_ADDR, RD_DATA).
- Upstream masters must hold valid and payload stable until ready, per AXI. The arbiter never withdraws a forwarded valid before its handshake.
- rst asserted mid-transaction aborts it: state goes to IDLE the next cycle and outputs drop. The downstream slave is reset together with the arbiter by system rule.
- No combinational path from axi_*ready to any upstream valid. Paths from upstream valid to downstream valid and from downstream ready to upstream ready are allowed.

## Structure
- Shared package additions:
  - state enum `arb_state_t`
  - master-id constants `ARB_F` and `ARB_M`
  - AXI resp constants OKAY/SLVERR/DECERR
- One sub-module, `rr_pick2`:
  - Combinational two-requester round-robin picker.
  - Inputs: req[1:0], last. Output: winner.
- The FSM, done flags and channel muxing stay in axi_bus_arbiter.

## Test plan
- Single F read, arready=1, rvalid 2 cycles later, rdata=0xDEADBEEF → f_rvalid with 0xDEADBEEF; m_* ready/valid stay 0 throughout; state back to IDLE.
- F and M reads both asserted in the same IDLE cycle after reset → M granted first (last=F); F granted on the next IDLE; then repeated ties alternate F, M, F.
- M store with wstrb=0100, wdata=0x00AB0000, awready delayed 3 cycles, wready immediate → axi_wvalid drops after 1 cycle, axi_awvalid after 4; WR_RESP is entered only after both; m_bvalid follows axi_bvalid.
- M asserts awvalid and arvalid together → write transaction completes first, then the read is granted.
- Slave returns rresp=2'b10 on an F read → f_rresp=2'b10 and the transaction completes normally.
- rst raised in RD_DATA while axi_rvalid=0 → next cycle all valid/ready outputs are 0 and state is IDLE; a fresh F read then completes correctly.

Source files
------------

// File: rtl/axi_bus_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite bus arbiter.
// Master ids, FSM state encoding and AXI response codes live here.
package axi_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_XFER = 3'd3,
        ST_WR_RESP = 3'd4
    } arb_state_t;

    // Master ids double as bit indices into the request vector
    localparam logic ARB_F = 1'b0;
    localparam logic ARB_M = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_bus_arbiter_rr_pick2.sv
// Combinational round-robin picker for two requesters.
// On a tie the requester that was not served last wins.
module rr_pick2
    import axi_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = ARB_F;
        if (req[ARB_F] && req[ARB_M]) begin
            winner = ~last;
        end else if (req[ARB_M]) begin
            winner = ARB_M;
        end
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Two-master AXI4-Lite arbiter: fetch (read-only) and mem (read/write) share
// one downstream port, one whole transaction at a time, round-robin.
module axi_bus_arbiter
    import axi_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     f_araddr,
    input  logic [2:0]            f_arprot,
    input  logic                  f_arvalid,
    output logic                  f_arready,
    output logic [DATA_W-1:0]     f_rdata,
    output logic [1:0]            f_rresp,
    output logic                  f_rvalid,
    input  logic                  f_rready,

    input  logic [ADDR_W-1:0]     m_araddr,
    input  logic [2:0]            m_arprot,
    input  logic                  m_arvalid,
    output logic                  m_arready,
    output logic [DATA_W-1:0]     m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    input  logic [ADDR_W-1:0]     m_awaddr,
    input  logic [2:0]            m_awprot,
    input  logic                  m_awvalid,
    output logic                  m_awready,
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wvalid,
    output logic                  m_wready,
    output logic [1:0]            m_bresp,
    output logic                  m_bvalid,
    input  logic                  m_bready,

    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    arb_state_t state_reg, state_next;
    logic       gnt_reg, gnt_next;
    logic       last_reg, last_next;
    logic       aw_done_reg, aw_done_next;
    logic       w_done_reg, w_done_next;

    logic [1:0] req;
    logic       winner;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req[ARB_F] = f_arvalid;
    assign req[ARB_M] = m_arvalid | m_awvalid;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_reg),
        .winner (winner)
    );

    assign ar_hs = axi_arvalid & axi_arready;
    assign r_hs  = axi_rvalid  & axi_rready;
    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;
    assign b_hs  = axi_bvalid  & axi_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= ARB_F;
            last_reg    <= ARB_F;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            last_reg    <= last_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        last_next    = last_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    gnt_next  = winner;
                    last_next = winner;
                    // A pending write from M takes precedence over its read
                    if (winner == ARB_M && m_awvalid) begin
                        state_next   = ST_WR_XFER;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                    end else begin
                        state_next = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (r_hs) state_next = ST_IDLE;
            end
            ST_WR_XFER: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Payloads pass straight through; only the valid/ready pairs are gated
    always_comb begin
        axi_araddr  = (gnt_reg == ARB_M) ? m_araddr : f_araddr;
        axi_arprot  = (gnt_reg == ARB_M) ? m_arprot : f_arprot;
        axi_awaddr  = m_awaddr;
        axi_awprot  = m_awprot;
        axi_wdata   = m_wdata;
        axi_wstrb   = m_wstrb;
        f_rdata     = axi_rdata;
        f_rresp     = axi_rresp;
        m_rdata     = axi_rdata;
        m_rresp     = axi_rresp;
        m_bresp     = axi_bresp;

        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        f_arready   = 1'b0;
        f_rvalid    = 1'b0;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;

        case (state_reg)
            ST_RD_ADDR: begin
                if (gnt_reg == ARB_M) begin
                    axi_arvalid = m_arvalid;
                    m_arready   = axi_arready;
                end else begin
                    axi_arvalid = f_arvalid;
                    f_arready   = axi_arready;
                end
            end
            ST_RD_DATA: begin
                if (gnt_reg == ARB_M) begin
                    axi_rready = m_rready;
                    m_rvalid   = axi_rvalid;
                end else begin
                    axi_rready = f_rready;
                    f_rvalid   = axi_rvalid;
                end
            end
            ST_WR_XFER: begin
                axi_awvalid = m_awvalid & ~aw_done_reg;
                m_awready   = axi_awready & ~aw_done_reg;
                axi_wvalid  = m_wvalid & ~w_done_reg;
                m_wready    = axi_wready & ~w_done_reg;
            end
            ST_WR_RESP: begin
                axi_bready = m_bready;
                m_bvalid   = axi_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: the downstream slave and both masters
// are driven by hand, and every expected value is written out explicitly.
module tb_axi_bus_arbiter;
    import axi_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_araddr;
    logic [2:0]  f_arprot;
    logic        f_arvalid, f_arready;
    logic [31:0] f_rdata;
    logic [1:0]  f_rresp;
    logic        f_rvalid, f_rready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADDR_F = 32'h0000_1000;
    localparam logic [31:0] ADDR_M = 32'h0000_2000;

    always #5 clk = ~clk;

    axi_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .f_araddr(f_araddr), .f_arprot(f_arprot), .f_arvalid(f_arvalid), .f_arready(f_arready),
        .f_rdata(f_rdata), .f_rresp(f_rresp), .f_rvalid(f_rvalid), .f_rready(f_rready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );

    // Every valid/ready output of the arbiter, and the subset facing M
    wire [11:0] vr_all = {f_arready, f_rvalid, m_arready, m_rvalid, m_awready, m_wready,
                          m_bvalid, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready};
    wire [4:0]  vr_m   = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    // One read round with both masters requesting at entry; winner drops its request
    // after the data beat and re-raises it so the next round is a tie again.
    task automatic tie_round(input logic exp_m, input string tag);
        tick();
        chk({tag, "_addr"}, axi_araddr, exp_m ? ADDR_M : ADDR_F);
        chk({tag, "_rdy"}, {m_arready, f_arready}, exp_m ? 2'b10 : 2'b01);
        tick();
        if (exp_m) m_arvalid = 1'b0; else f_arvalid = 1'b0;
        axi_rvalid = 1'b1;
        axi_rdata  = exp_m ? 32'hAAAA_0001 : 32'hBBBB_0002;
        settle();
        chk({tag, "_rv"}, {m_rvalid, f_rvalid}, exp_m ? 2'b10 : 2'b01);
        tick();
        axi_rvalid = 1'b0;
        if (exp_m) m_arvalid = 1'b1; else f_arvalid = 1'b1;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        f_araddr = ADDR_F; f_arprot = 3'd0; f_arvalid = 1'b0; f_rready = 1'b0;
        m_araddr = ADDR_M; m_arprot = 3'd0; m_arvalid = 1'b0; m_rready = 1'b0;
        m_awaddr = 32'h0000_3000; m_awprot = 3'd0; m_awvalid = 1'b0;
        m_wdata = 32'd0; m_wstrb = 4'd0; m_wvalid = 1'b0; m_bready = 1'b0;
        axi_arready = 1'b0; axi_rdata = 32'd0; axi_rresp = RESP_OKAY; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = RESP_OKAY; axi_bvalid = 1'b0;

        // Reset state
        do_reset();
        chk("reset_vr", vr_all, 12'h000);

        // Single F read, data two cycles after the address
        f_arvalid = 1'b1; f_rready = 1'b1; axi_arready = 1'b1;
        settle();
        chk("f1_idle_vr", vr_all, 12'h000);
        tick();
        chk("f1_arvalid", axi_arvalid, 1'b1);
        chk("f1_araddr", axi_araddr, ADDR_F);
        chk("f1_arready", f_arready, 1'b1);
        chk("f1_m_quiet", vr_m, 5'h00);
        tick();
        f_arvalid = 1'b0;
        settle();
        chk("f1_rready", axi_rready, 1'b1);
        chk("f1_rv_wait", f_rvalid, 1'b0);
        tick();
        axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF;
        settle();
        chk("f1_rvalid", f_rvalid, 1'b1);
        chk("f1_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("f1_m_quiet2", vr_m, 5'h00);
        tick();
        axi_rvalid = 1'b0;
        settle();
        chk("f1_done_vr", vr_all, 12'h000);

        // Repeated read ties: M first after reset, then alternating
        do_reset();
        m_rready = 1'b1;
        f_arvalid = 1'b1; m_arvalid = 1'b1;
        settle();
        tie_round(1'b1, "tie1_m");
        tie_round(1'b0, "tie2_f");
        tie_round(1'b1, "tie3_m");
        tie_round(1'b0, "tie4_f");
        f_arvalid = 1'b0; m_arvalid = 1'b0;
        settle();
        chk("tie_idle_vr", vr_all, 12'h000);

        // M store: wready immediate, awready only in the fourth transfer cycle
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_wdata = 32'h00AB_0000; m_wstrb = 4'b0100;
        m_bready = 1'b1; axi_awready = 1'b0; axi_wready = 1'b1; axi_arready = 1'b0;
        tick();
        chk("wr_c1_aw", axi_awvalid, 1'b1);
        chk("wr_c1_w", axi_wvalid, 1'b1);
        chk("wr_wdata", axi_wdata, 32'h00AB_0000);
        chk("wr_wstrb", axi_wstrb, 4'b0100);
        chk("wr_wready", m_wready, 1'b1);
        tick();
        m_wvalid = 1'b0;
        settle();
        chk("wr_c2_w", axi_wvalid, 1'b0);
        chk("wr_c2_aw", axi_awvalid, 1'b1);
        tick();
        chk("wr_c3_aw", axi_awvalid, 1'b1);
        chk("wr_c3_bready", axi_bready, 1'b0);
        tick();
        axi_awready = 1'b1;
        settle();
        chk("wr_c4_awready", m_awready, 1'b1);
        chk("wr_c4_bready", axi_bready, 1'b0);
        tick();
        m_awvalid = 1'b0; axi_awready = 1'b0;
        settle();
        chk("wr_resp_aw", axi_awvalid, 1'b0);
        chk("wr_resp_bready", axi_bready, 1'b1);
        chk("wr_resp_bv0", m_bvalid, 1'b0);
        tick();
        axi_bvalid = 1'b1; axi_bresp = RESP_OKAY;
        settle();
        chk("wr_bvalid", m_bvalid, 1'b1);
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("wr_done_vr", vr_all, 12'h000);

        // M write and read together: write first, then the read
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_arvalid = 1'b1;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1;
        tick();
        chk("wa_aw_first", {axi_awvalid, axi_arvalid}, 2'b10);
        chk("wa_no_arready", m_arready, 1'b0);
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0; axi_bvalid = 1'b1; axi_bresp = RESP_SLVERR;
        settle();
        chk("wa_bvalid", m_bvalid, 1'b1);
        chk("wa_bresp", m_bresp, RESP_SLVERR);
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("wa_idle_vr", vr_all, 12'h000);
        tick();
        chk("wa_rd_arvalid", axi_arvalid, 1'b1);
        chk("wa_rd_araddr", axi_araddr, ADDR_M);
        chk("wa_rd_arready", m_arready, 1'b1);
        tick();
        m_arvalid = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'hCAFE_F00D;
        settle();
        chk("wa_rd_rvalid", m_rvalid, 1'b1);
        chk("wa_rd_rdata", m_rdata, 32'hCAFE_F00D);
        tick();
        axi_rvalid = 1'b0;
        settle();

        // F read answered with SLVERR
        f_arvalid = 1'b1;
        tick();
        chk("err_arvalid", axi_arvalid, 1'b1);
        tick();
        f_arvalid = 1'b0; axi_rvalid = 1'b1; axi_rresp = RESP_SLVERR;
        settle();
        chk("err_rvalid", f_rvalid, 1'b1);
        chk("err_rresp", f_rresp, RESP_SLVERR);
        tick();
        axi_rvalid = 1'b0; axi_rresp = RESP_OKAY;
        settle();
        chk("err_done_vr", vr_all, 12'h000);

        // Reset while waiting for read data, then a fresh read
        f_arvalid = 1'b1;
        tick();
        tick();
        f_arvalid = 1'b0;
        settle();
        chk("rst_in_rdata", axi_rready, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_abort_vr", vr_all, 12'h000);
        rst = 1'b0;
        settle();
        f_araddr = 32'h0000_4444; f_arvalid = 1'b1;
        tick();
        chk("post_arvalid", axi_arvalid, 1'b1);
        chk("post_araddr", axi_araddr, 32'h0000_4444);
        tick();
        f_arvalid = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'h1234_5678;
        settle();
        chk("post_rvalid", f_rvalid, 1'b1);
        chk("post_rdata", f_rdata, 32'h1234_5678);
        tick();
        axi_rvalid = 1'b0;
        settle();
        chk("post_done_vr", vr_all, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
